// File: rtl/i2c_slave_router.sv
// i2c_slave_router: snoops the master's SCL/SDA on the system clock, decodes the
// 7-bit address after every START and routes the addressed slave's SDA/SCL back
// to the master. Unaddressed slaves are masked to the idle (high) level, and an
// address that matches no slave leaves SDA high so the master sees a NACK.
// Optional feature: define I2C_ROUTER_GENERAL_CALL_EN to make address 7'h00 with
// a write bit broadcast to every slave.
module i2c_slave_router #(
    parameter int         NUM_SLAVES = 3,
    parameter logic [6:0] BASE_ADDR  = 7'h50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCL_M,
    input  logic                  SDA_M,
    input  logic [NUM_SLAVES-1:0] SCL_S,
    input  logic [NUM_SLAVES-1:0] SDA_S,
    output logic                  SCL_O,
    output logic                  SDA_O,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  busy,
    output logic                  nack_err
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        ROUTE,
        HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic                    busy_q, busy_d;
    logic                    nackErr_q, nackErr_d;
    logic [2:0]              bitCnt_q, bitCnt_d;
    logic [6:0]              shift_q, shift_d;
    logic                    scl_q, sda_q;

    logic                    startDet, stopDet, sclRise;
    logic [7:0]              addrExt, baseExt, offset;
    logic                    inRange;
    logic                    gcWrite, gcRead;
    logic [NUM_SLAVES-1:0]   oneHot;

    // START/STOP need SCL stable high across the sample, so a simultaneous
    // SCL and SDA change can never be mistaken for either condition.
    assign startDet = SCL_M & scl_q & sda_q & ~SDA_M;
    assign stopDet  = SCL_M & scl_q & ~sda_q & SDA_M;
    assign sclRise  = ~scl_q & SCL_M;

    // On the 8th rise the shift register still holds the seven address bits;
    // the bit arriving on that rise is the read/write flag.
    assign addrExt = {1'b0, shift_q};
    assign baseExt = {1'b0, BASE_ADDR};
    assign offset  = addrExt - baseExt;
    assign inRange = (addrExt >= baseExt) && (addrExt < baseExt + 8'(NUM_SLAVES));

`ifdef I2C_ROUTER_GENERAL_CALL_EN
    assign gcWrite = (shift_q == 7'h00) && !SDA_M;
    assign gcRead  = (shift_q == 7'h00) && SDA_M;
`else
    assign gcWrite = 1'b0;
    assign gcRead  = 1'b0;
`endif

    // Turn the address offset into a one-hot slave select.
    always_comb begin
        oneHot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            oneHot[i] = (offset == 8'(i));
        end
    end

    // Next-state logic: START always restarts address decode, STOP always ends
    // the transfer, otherwise the address byte is shifted in during ADDR.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        nackErr_d = 1'b0;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        case (state_q)
            IDLE: begin
                if (startDet) begin
                    state_d  = ADDR;
                    busy_d   = 1'b1;
                    sel_d    = '0;
                    bitCnt_d = 3'd0;
                    shift_d  = 7'd0;
                end
            end
            default: begin
                if (startDet) begin
                    state_d  = ADDR;
                    sel_d    = '0;
                    bitCnt_d = 3'd0;
                    shift_d  = 7'd0;
                end else if (stopDet) begin
                    state_d  = IDLE;
                    sel_d    = '0;
                    busy_d   = 1'b0;
                    bitCnt_d = 3'd0;
                end else if (state_q == ADDR && sclRise) begin
                    shift_d  = {shift_q[5:0], SDA_M};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        bitCnt_d = 3'd0;
                        if (gcWrite) begin
                            sel_d   = '1;
                            state_d = ROUTE;
                        end else if (inRange && !gcRead) begin
                            sel_d   = oneHot;
                            state_d = ROUTE;
                        end else begin
                            sel_d     = '0;
                            nackErr_d = 1'b1;
                            state_d   = HOLD;
                        end
                    end
                end
            end
        endcase
    end

    // State and bus-sample registers; reset returns straight to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            nackErr_q <= 1'b0;
            bitCnt_q  <= 3'd0;
            shift_q   <= 7'd0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            nackErr_q <= nackErr_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            scl_q     <= SCL_M;
            sda_q     <= SDA_M;
        end
    end

    // Return path is a wired-AND of the selected slaves; with nothing selected
    // the master sees an idle (released) bus.
    assign SDA_O    = (|sel_q) ? &(SDA_S | ~sel_q) : 1'b1;
    assign SCL_O    = (|sel_q) ? &(SCL_S | ~sel_q) : 1'b1;
    assign sel      = sel_q;
    assign busy     = busy_q;
    assign nack_err = nackErr_q;

endmodule

// File: tb/tb_i2c_slave_router.sv
// tb_i2c_slave_router: drives I2C transactions from the master side, keeps a
// transaction-level model of which slave should be routed, and compares every
// cycle plus a set of hand-computed expectations.
module tb_i2c_slave_router;

    localparam int         NS   = 3;
    localparam logic [6:0] BASE = 7'h50;

    logic          clk = 1'b0;
    logic          rst;
    logic          SCL_M, SDA_M;
    logic [NS-1:0] SCL_S, SDA_S;
    logic          SCL_O, SDA_O;
    logic [NS-1:0] sel;
    logic          busy, nack_err;

    int checkCount = 0;
    int passCount  = 0;
    int nackCycles = 0;
    bit checkEn    = 1'b0;

    logic [NS-1:0] expSel;
    logic          expBusy;
    logic          expNack;

    i2c_slave_router #(.NUM_SLAVES(NS), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .SCL_M(SCL_M), .SDA_M(SDA_M),
        .SCL_S(SCL_S), .SDA_S(SDA_S), .SCL_O(SCL_O), .SDA_O(SDA_O),
        .sel(sel), .busy(busy), .nack_err(nack_err)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Open-drain line seen by the master: low if any selected slave pulls low.
    function automatic logic wiredLine(input logic [NS-1:0] mask, input logic [NS-1:0] lines);
        for (int i = 0; i < NS; i++) begin
            if (mask[i] && !lines[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Which slaves an address byte should select (zero means unmatched).
    function automatic logic [NS-1:0] modelSel(input logic [6:0] a, input logic rw);
        int            idx;
        logic [NS-1:0] one;
        one = 1;
        idx = int'(a) - int'(BASE);
`ifdef I2C_ROUTER_GENERAL_CALL_EN
        if (a == 7'h00) return rw ? '0 : '1;
`endif
        if (idx >= 0 && idx < NS) return one << idx;
        return '0;
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("sel", 32'(sel), 32'(expSel));
            checkOutput("busy", 32'(busy), 32'(expBusy));
            checkOutput("nack_err", 32'(nack_err), 32'(expNack));
            checkOutput("SDA_O", 32'(SDA_O), 32'(wiredLine(expSel, SDA_S)));
            checkOutput("SCL_O", 32'(SCL_O), 32'(wiredLine(expSel, SCL_S)));
            if (nack_err) nackCycles++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        expNack = 1'b0;
    endtask

    task automatic applyStimulus(input logic scl, input logic sda);
        SCL_M = scl;
        SDA_M = sda;
        step();
    endtask

    task automatic startCond();
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        expBusy = 1'b1;
        expSel  = '0;
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic repStart();
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        expSel = '0;
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic stopCond();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        expSel  = '0;
        expBusy = 1'b0;
        step();
    endtask

    task automatic sendBit(input logic b);
        applyStimulus(1'b0, b);
        applyStimulus(1'b1, b);
        step();
        applyStimulus(1'b0, b);
    endtask

    task automatic sendAddr(input logic [6:0] a, input logic rw);
        logic [7:0] byteVal;
        byteVal = {a, rw};
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b0, byteVal[i]);
            applyStimulus(1'b1, byteVal[i]);
            if (i == 0) begin
                expSel  = modelSel(a, rw);
                expNack = (modelSel(a, rw) == '0);
            end
            step();
            applyStimulus(1'b0, byteVal[i]);
        end
    endtask

    task automatic ackBit(input string name, input logic [NS-1:0] slaveSda, input logic expSda);
        SDA_S = slaveSda;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput(name, 32'(SDA_O), 32'(expSda));
        step();
        applyStimulus(1'b0, 1'b1);
        SDA_S = '1;
    endtask

    initial begin
        logic [7:0] captured;
        logic [7:0] readData;
        int         lowCount;
        int         nackBefore;

        rst     = 1'b1;
        SCL_M   = 1'b1;
        SDA_M   = 1'b1;
        SCL_S   = '1;
        SDA_S   = '1;
        expSel  = '0;
        expBusy = 1'b0;
        expNack = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        checkEn = 1'b1;
        checkOutput("resetSel", 32'(sel), 32'h0);
        checkOutput("resetBusy", 32'(busy), 32'h0);
        checkOutput("resetSda", 32'(SDA_O), 32'h1);
        checkOutput("resetScl", 32'(SCL_O), 32'h1);

        // Write to 7'h51, slave 1 ACKs.
        startCond();
        checkOutput("t1BusyAfterStart", 32'(busy), 32'h1);
        sendAddr(7'h51, 1'b0);
        checkOutput("t1Sel", 32'(sel), 32'h2);
        checkOutput("t1Busy", 32'(busy), 32'h1);
        ackBit("t1Ack", 3'b101, 1'b0);
        stopCond();
        checkOutput("t1SelStop", 32'(sel), 32'h0);
        checkOutput("t1BusyStop", 32'(busy), 32'h0);

        // Unmatched address 7'h60: NACK and one error pulse.
        nackBefore = nackCycles;
        startCond();
        sendAddr(7'h60, 1'b0);
        checkOutput("t2Sel", 32'(sel), 32'h0);
        ackBit("t2Nack", 3'b000, 1'b1);
        checkOutput("t2NackPulses", 32'(nackCycles - nackBefore), 32'd1);
        stopCond();

        // Read from 7'h52, slave 2 returns 8'hA5.
        readData = 8'hA5;
        captured = 8'h00;
        startCond();
        sendAddr(7'h52, 1'b1);
        checkOutput("t3Sel", 32'(sel), 32'h4);
        ackBit("t3Ack", 3'b011, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            SDA_S = {readData[i], 2'b00};
            applyStimulus(1'b0, 1'b1);
            applyStimulus(1'b1, 1'b1);
            captured = {captured[6:0], SDA_O};
            step();
            applyStimulus(1'b0, 1'b1);
        end
        SDA_S = '1;
        checkOutput("t3ReadByte", 32'(captured), 32'hA5);
        ackBit("t3MasterNack", 3'b111, 1'b1);
        stopCond();

        // Repeated START moves the route from slave 0 to slave 2.
        startCond();
        sendAddr(7'h50, 1'b0);
        checkOutput("t4SelFirst", 32'(sel), 32'h1);
        ackBit("t4Ack0", 3'b110, 1'b0);
        repStart();
        checkOutput("t4SelCleared", 32'(sel), 32'h0);
        checkOutput("t4BusyHeld", 32'(busy), 32'h1);
        sendAddr(7'h52, 1'b0);
        checkOutput("t4SelSecond", 32'(sel), 32'h4);
        checkOutput("t4BusyStill", 32'(busy), 32'h1);
        ackBit("t4Ack2", 3'b011, 1'b0);
        stopCond();

        // Clock stretching by the selected slave only.
        startCond();
        sendAddr(7'h50, 1'b0);
        ackBit("t5Ack", 3'b110, 1'b0);
        SCL_S = 3'b110;
        lowCount = 0;
        repeat (20) begin
            step();
            if (SCL_O == 1'b0) lowCount++;
        end
        SCL_S = '1;
        step();
        checkOutput("t5StretchLow", 32'(lowCount), 32'd20);
        checkOutput("t5StretchRelease", 32'(SCL_O), 32'h1);
        SCL_S = 3'b011;
        step();
        checkOutput("t5UnselStretch", 32'(SCL_O), 32'h1);
        SCL_S = '1;
        stopCond();

        // Reset in the middle of the address byte, then a clean transfer.
        startCond();
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        rst = 1'b1;
        step();
        expSel  = '0;
        expBusy = 1'b0;
        rst = 1'b0;
        checkOutput("t6ResetSel", 32'(sel), 32'h0);
        checkOutput("t6ResetBusy", 32'(busy), 32'h0);
        checkOutput("t6ResetSda", 32'(SDA_O), 32'h1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        step();
        startCond();
        sendAddr(7'h50, 1'b0);
        checkOutput("t6SelAfterReset", 32'(sel), 32'h1);
        ackBit("t6Ack", 3'b110, 1'b0);
        stopCond();

        // Address 7'h00 write: broadcast only when general call is enabled.
        nackBefore = nackCycles;
        startCond();
        sendAddr(7'h00, 1'b0);
`ifdef I2C_ROUTER_GENERAL_CALL_EN
        checkOutput("gcSel", 32'(sel), 32'h7);
        ackBit("gcAck", 3'b110, 1'b0);
        checkOutput("gcNoNack", 32'(nackCycles - nackBefore), 32'd0);
`else
        checkOutput("addr00Sel", 32'(sel), 32'h0);
        ackBit("addr00Nack", 3'b000, 1'b1);
        checkOutput("addr00NackPulses", 32'(nackCycles - nackBefore), 32'd1);
`endif
        stopCond();

        checkEn = 1'b0;
        step();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
